// File: rtl/ddr3_tg_pkg.sv
// rtl/ddr3_tg_pkg.sv - shared state codes, pattern modes and pattern helpers for the DDR3 traffic generator
package ddr3_tg_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] MODE_INCR = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_ADDR = 2'd2;
  localparam logic [1:0] MODE_ZERO = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois form: feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] lane_pattern(input logic [1:0] mode, input logic [31:0] beat_n,
                                               input logic [31:0] lfsr, input logic [31:0] addr_beat,
                                               input logic [31:0] lane);
    case (mode)
      MODE_INCR: return beat_n;
      MODE_LFSR: return lfsr ^ lane;
      MODE_ADDR: return addr_beat + lane;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_tg_pattern_gen.sv
// rtl/ddr3_tg_pattern_gen.sv - registered beat pattern state producing one DATA_W beat combinationally
module ddr3_tg_pattern_gen
  import ddr3_tg_pkg::*;
#(
  parameter int          DATA_W    = 256,
  parameter int          ADDR_W    = 28,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  output logic [DATA_W-1:0] data
);

  localparam logic [4:0] LAST_BIB = 5'(BURST_LEN - 1);

  logic [31:0] beat_n;
  logic [31:0] lfsr;
  logic [4:0]  bib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_n <= '0;
      lfsr   <= LFSR_SEED;
      bib    <= '0;
    end else if (clear) begin
      beat_n <= '0;
      lfsr   <= LFSR_SEED;
      bib    <= '0;
    end else if (advance) begin
      beat_n <= beat_n + 32'd1;
      lfsr   <= lfsr_step(lfsr);
      bib    <= (bib == LAST_BIB) ? 5'd0 : bib + 5'd1;
    end
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      data[k*32 +: 32] = lane_pattern(mode, beat_n, lfsr, 32'(base) + 32'(bib), 32'(k));
    end
  end

endmodule

// File: rtl/ddr3_axi_traffic_gen.sv
// rtl/ddr3_axi_traffic_gen.sv - DDR3 AXI write-then-read traffic generator with beat checker and soak looping
module ddr3_axi_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter int                DATA_W     = 256,
  parameter int                ADDR_W     = 28,
  parameter int                BURST_LEN  = 16,
  parameter int                ADDR_STEP  = 128,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 28'hFFF_F80,
  parameter logic [31:0]       LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                core_clk,
  input  logic                i_rst_n,
  input  logic                ddr_init_done,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic                i_loop,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [3:0]          axi_awlen,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wready,
  input  logic                axi_wusero_last,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [3:0]          axi_arlen,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic                axi_rvalid,
  input  logic                axi_rlast,
  output logic                busy,
  output logic                wr_finish,
  output logic                rd_finish,
  output logic                err_flag,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [15:0]         pass_cnt
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_STEP[ADDR_W-1:0];

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        mode_q;
  logic              init_s1, init_s2, init_s3;
  logic              idle_like, start_evt, restart;
  logic              wr_beat, rd_beat, wr_burst_end, rd_burst_end, last_burst;
  logic [DATA_W-1:0] wr_data, rd_exp;
  logic              mism_q;
  logic [ADDR_W-1:0] mism_addr_q;

  always_ff @(posedge core_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_s1 <= 1'b0;
      init_s2 <= 1'b0;
      init_s3 <= 1'b0;
    end else begin
      init_s1 <= ddr_init_done;
      init_s2 <= init_s1;
      init_s3 <= init_s2;
    end
  end

  assign idle_like    = (state == ST_IDLE) || (state == ST_DONE);
  assign start_evt    = idle_like && ((init_s2 && !init_s3) || (i_start && init_s2));
  assign restart      = start_evt || ((state == ST_DONE) && i_loop);
  assign wr_beat      = (state == ST_WR_DATA) && axi_wready;
  assign rd_beat      = (state == ST_RD_DATA) && axi_rvalid;
  assign wr_burst_end = wr_beat && axi_wusero_last;
  assign rd_burst_end = rd_beat && axi_rlast;
  assign last_burst   = (cur_addr == END_ADDR);

  always_ff @(posedge core_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cur_addr  <= START_ADDR;
      wr_finish <= 1'b0;
      rd_finish <= 1'b0;
      pass_cnt  <= '0;
      mode_q    <= MODE_INCR;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WR_ADDR: if (axi_awready) state <= ST_WR_DATA;
        ST_WR_DATA: if (wr_burst_end) begin
          if (last_burst) begin
            state     <= ST_RD_ADDR;
            wr_finish <= 1'b1;
            cur_addr  <= START_ADDR;
          end else begin
            state    <= ST_WR_ADDR;
            cur_addr <= cur_addr + STEP;
          end
        end
        ST_RD_ADDR: if (axi_arready) state <= ST_RD_DATA;
        ST_RD_DATA: if (rd_burst_end) begin
          if (last_burst) begin
            state     <= ST_DONE;
            rd_finish <= 1'b1;
            cur_addr  <= START_ADDR;
            pass_cnt  <= pass_cnt + 16'd1;
          end else begin
            state    <= ST_RD_ADDR;
            cur_addr <= cur_addr + STEP;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
      if (restart) begin
        state     <= ST_WR_ADDR;
        cur_addr  <= START_ADDR;
        wr_finish <= 1'b0;
        rd_finish <= 1'b0;
        mode_q    <= i_mode;
      end
    end
  end

  ddr3_tg_pattern_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .LFSR_SEED(LFSR_SEED)
  ) u_wr_pat (
    .clk(core_clk), .rst_n(i_rst_n), .clear(restart), .advance(wr_beat),
    .mode(mode_q), .base(cur_addr), .data(wr_data)
  );

  // The read generator restarts from beat 0 when the write phase hands over.
  ddr3_tg_pattern_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .LFSR_SEED(LFSR_SEED)
  ) u_rd_pat (
    .clk(core_clk), .rst_n(i_rst_n), .clear(restart || (wr_burst_end && last_burst)),
    .advance(rd_beat), .mode(mode_q), .base(cur_addr), .data(rd_exp)
  );

  always_ff @(posedge core_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mism_q         <= 1'b0;
      mism_addr_q    <= '0;
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      mism_q      <= rd_beat && (axi_rdata != rd_exp);
      mism_addr_q <= cur_addr;
      if (restart) begin
        err_flag       <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
      end else if (mism_q) begin
        err_flag <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (!err_flag) first_err_addr <= mism_addr_q;
      end
    end
  end

  assign busy        = !idle_like;
  assign axi_awvalid = (state == ST_WR_ADDR);
  assign axi_arvalid = (state == ST_RD_ADDR);
  assign axi_awaddr  = axi_awvalid ? cur_addr : '0;
  assign axi_araddr  = axi_arvalid ? cur_addr : '0;
  assign axi_awlen   = 4'(BURST_LEN - 1);
  assign axi_arlen   = 4'(BURST_LEN - 1);
  assign axi_wstrb   = '1;
  assign axi_wdata   = (state == ST_WR_DATA) ? wr_data : '0;

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// tb/tb_ddr3_axi_traffic_gen.sv - randomized AXI slave memory bench with reference pattern model
module tb_ddr3_axi_traffic_gen;

  localparam int          DW    = 128;
  localparam int          AW    = 28;
  localparam int          BL    = 8;
  localparam int          STEP  = 128;
  localparam int          NB    = 4;
  localparam int          LANES = DW / 32;
  localparam logic [27:0] START_A = 28'h0;
  localparam logic [27:0] END_A   = 28'h180;
  localparam logic [31:0] SEED    = 32'hACE1_2468;
  localparam logic [31:0] POLY    = 32'h8020_0003;

  logic          core_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          ddr_init_done = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic          i_loop = 1'b0;
  logic [AW-1:0] axi_awaddr, axi_araddr, first_err_addr;
  logic [3:0]    axi_awlen, axi_arlen;
  logic          axi_awvalid, axi_arvalid, busy, wr_finish, rd_finish, err_flag;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_wusero_last = 1'b0;
  logic          axi_arready = 1'b0, axi_rvalid = 1'b0, axi_rlast = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [DW-1:0] axi_rdata = '0;
  logic [DW/8-1:0] axi_wstrb;
  logic [15:0]   err_cnt, pass_cnt;

  ddr3_axi_traffic_gen #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .ADDR_STEP(STEP),
    .START_ADDR(START_A), .END_ADDR(END_A), .LFSR_SEED(SEED)
  ) dut (
    .core_clk(core_clk), .i_rst_n(i_rst_n), .ddr_init_done(ddr_init_done), .i_start(i_start),
    .i_mode(i_mode), .i_loop(i_loop),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .busy(busy), .wr_finish(wr_finish), .rd_finish(rd_finish), .err_flag(err_flag),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .pass_cnt(pass_cnt)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0, passed = 0;
  logic [DW-1:0] mem [NB*BL];
  int cur_mode = 0;
  bit corrupt_all = 0;
  logic [27:0] corrupt_base = 28'hFFF_FFFF;
  int corrupt_beat = -1, corrupt_bit = 0;
  bit long_rd = 0;
  int long_len = 0;
  int exp_err = 0, exp_pass = 0, aw_hs = 0, ar_hs = 0;
  logic [27:0] exp_first = '0;

  // Expected beat straight from the pattern definition; LFSR value found by stepping from the seed.
  function automatic logic [DW-1:0] ref_beat(input int m, input int n, input logic [31:0] base, input int bib);
    logic [DW-1:0] d;
    logic [31:0] l;
    l = SEED;
    if (m == 1) for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
    for (int k = 0; k < LANES; k++) begin
      case (m)
        0:       d[k*32 +: 32] = n;
        1:       d[k*32 +: 32] = l ^ k;
        2:       d[k*32 +: 32] = base + bib + k;
        default: d[k*32 +: 32] = 32'h0;
      endcase
    end
    return d;
  endfunction

  function automatic int mem_idx(input logic [27:0] base, input int b);
    return int'((base - START_A) / STEP) * BL + b;
  endfunction

  task automatic pulse_start();
    @(negedge core_clk); i_start = 1'b1;
    @(negedge core_clk); i_start = 1'b0;
  endtask

  task automatic serve(input int target, input int max_cyc, input bit abort, input int pulse_pass);
    int cyc = 0, passes = 0, aw_in_pass = 0, wn = 0, rn = 0, wb = 0, rb = 0, rlen = BL;
    bit wact = 0, ract = 0, chk_wf = 0, first_set = 0, pulsed = 0;
    logic [27:0] wbase = '0, rbase = '0, exp_addr = START_A;
    logic [DW-1:0] d, e;
    while (1) begin
      @(negedge core_clk);
      cyc++;
      if (chk_wf) begin
        checks++;
        if (wr_finish !== 1'b1) $display("FAIL wr_finish_after_write got=%b want=1", wr_finish); else passed++;
        chk_wf = 0;
      end
      if (abort && wact && wb >= 2) break;
      if (passes >= target && !busy) break;
      if (cyc > max_cyc) begin
        checks++;
        $display("FAIL serve_timeout cycles=%0d passes=%0d want=%0d", cyc, passes, target);
        break;
      end
      axi_wready = 1'b0; axi_wusero_last = 1'b0;
      if (wact && $urandom_range(0, 3) != 0) begin
        axi_wready = 1'b1;
        axi_wusero_last = (wb == BL - 1);
        e = ref_beat(cur_mode, wn, wbase, wb);
        checks++;
        if (axi_wdata !== e) $display("FAIL wdata base=%h beat=%0d got=%h want=%h", wbase, wb, axi_wdata, e);
        else passed++;
        mem[mem_idx(wbase, wb)] = axi_wdata;
        wb++; wn++;
        if (wb == BL) begin
          wact = 0;
          if (wbase == END_A) begin wn = 0; chk_wf = 1; end
        end
      end
      axi_awready = 1'b0;
      if (axi_awvalid && $urandom_range(0, 2) != 0) begin
        axi_awready = 1'b1;
        checks++;
        if (axi_awaddr !== exp_addr) $display("FAIL awaddr got=%h want=%h", axi_awaddr, exp_addr); else passed++;
        aw_hs++;
        if (aw_in_pass == 0) begin exp_err = 0; exp_first = '0; first_set = 0; end
        aw_in_pass++;
        wact = 1; wbase = axi_awaddr; wb = 0;
        exp_addr = (exp_addr == END_A) ? START_A : exp_addr + 28'(STEP);
      end
      if (i_loop && passes == target - 1 && aw_in_pass > 0) i_loop = 1'b0;
      i_start = 1'b0;
      if (passes == pulse_pass && aw_in_pass == 2 && !pulsed) begin i_start = 1'b1; pulsed = 1; end
      axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
      if (ract && ((long_rd && rbase == START_A) || $urandom_range(0, 3) != 0)) begin
        rlen = (long_rd && rbase == START_A) ? long_len : BL;
        e = ref_beat(cur_mode, rn, rbase, rb);
        d = (rb < BL) ? mem[mem_idx(rbase, rb)] : e;
        if (corrupt_all || (rbase == corrupt_base && rb == corrupt_beat)) d[corrupt_bit] = ~d[corrupt_bit];
        axi_rvalid = 1'b1; axi_rdata = d; axi_rlast = (rb == rlen - 1);
        if (d !== e) begin
          if (!first_set) begin exp_first = rbase; first_set = 1; end
          if (exp_err < 65535) exp_err++;
        end
        rb++; rn++;
        if (rb == rlen) begin
          ract = 0;
          if (rbase == END_A) begin rn = 0; passes++; aw_in_pass = 0; end
        end
      end
      axi_arready = 1'b0;
      if (axi_arvalid && $urandom_range(0, 2) != 0) begin
        axi_arready = 1'b1;
        checks++;
        if (axi_araddr !== exp_addr) $display("FAIL araddr got=%h want=%h", axi_araddr, exp_addr); else passed++;
        ar_hs++;
        ract = 1; rbase = axi_araddr; rb = 0;
        exp_addr = (exp_addr == END_A) ? START_A : exp_addr + 28'(STEP);
      end
    end
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_last = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0; i_start = 1'b0;
  endtask

  task automatic check_pass_result(input string name, input int want_hs);
    repeat (2) @(negedge core_clk);
    checks++; if (busy !== 1'b0) $display("FAIL %s_busy got=%b want=0", name, busy); else passed++;
    checks++; if (rd_finish !== 1'b1) $display("FAIL %s_rd_finish got=%b want=1", name, rd_finish); else passed++;
    checks++; if (pass_cnt !== 16'(exp_pass)) $display("FAIL %s_pass_cnt got=%0d want=%0d", name, pass_cnt, exp_pass); else passed++;
    checks++; if (aw_hs !== want_hs) $display("FAIL %s_aw_count got=%0d want=%0d", name, aw_hs, want_hs); else passed++;
    checks++; if (ar_hs !== want_hs) $display("FAIL %s_ar_count got=%0d want=%0d", name, ar_hs, want_hs); else passed++;
    checks++; if (err_cnt !== 16'(exp_err)) $display("FAIL %s_err_cnt got=%0d want=%0d", name, err_cnt, exp_err); else passed++;
    checks++; if (err_flag !== (exp_err != 0)) $display("FAIL %s_err_flag got=%b want=%b", name, err_flag, exp_err != 0); else passed++;
    checks++; if (first_err_addr !== exp_first) $display("FAIL %s_first_err got=%h want=%h", name, first_err_addr, exp_first); else passed++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge core_clk);
    checks++; if ({axi_awvalid, axi_arvalid, busy, wr_finish, rd_finish, err_flag} !== 6'b0)
      $display("FAIL reset_flags got=%b want=000000", {axi_awvalid, axi_arvalid, busy, wr_finish, rd_finish, err_flag}); else passed++;
    checks++; if ({err_cnt, pass_cnt} !== 32'h0) $display("FAIL reset_counts got=%h want=0", {err_cnt, pass_cnt}); else passed++;
    checks++; if ({axi_awaddr, axi_araddr, first_err_addr} !== '0) $display("FAIL reset_addrs got=%h want=0", {axi_awaddr, axi_araddr, first_err_addr}); else passed++;
    checks++; if (axi_wdata !== '0) $display("FAIL reset_wdata got=%h want=0", axi_wdata); else passed++;
    checks++; if ({axi_awlen, axi_arlen} !== 8'h77) $display("FAIL reset_len got=%h want=77", {axi_awlen, axi_arlen}); else passed++;
    checks++; if (axi_wstrb !== '1) $display("FAIL reset_wstrb got=%h want=all ones", axi_wstrb); else passed++;
    i_rst_n = 1'b1;
    pulse_start();
    repeat (4) @(negedge core_clk);
    checks++; if (busy !== 1'b0) $display("FAIL start_without_init got=%b want=0", busy); else passed++;
  endtask

  task automatic test_incr_basic();
    cur_mode = 0; i_mode = 2'd0; aw_hs = 0; ar_hs = 0;
    ddr_init_done = 1'b1;
    serve(1, 3000, 0, -1);
    exp_pass++;
    check_pass_result("incr", NB);
    checks++; if (wr_finish !== 1'b1) $display("FAIL incr_wr_finish got=%b want=1", wr_finish); else passed++;
  endtask

  task automatic test_lfsr_error();
    cur_mode = 1; i_mode = 2'd1; aw_hs = 0; ar_hs = 0;
    corrupt_base = 28'h100; corrupt_beat = 2; corrupt_bit = 5;
    pulse_start();
    serve(1, 3000, 0, -1);
    exp_pass++;
    check_pass_result("lfsr_err", NB);
    corrupt_base = 28'hFFF_FFFF; corrupt_beat = -1;
  endtask

  task automatic test_loop();
    cur_mode = $urandom_range(0, 2); i_mode = 2'(cur_mode); aw_hs = 0; ar_hs = 0;
    i_loop = 1'b1;
    pulse_start();
    serve(3, 8000, 0, 1);
    exp_pass += 3;
    check_pass_result("loop", 3 * NB);
  endtask

  task automatic test_reset_mid();
    cur_mode = $urandom_range(0, 2); i_mode = 2'(cur_mode); aw_hs = 0; ar_hs = 0;
    pulse_start();
    serve(1, 3000, 1, -1);
    checks++; if (busy !== 1'b1) $display("FAIL midreset_busy_before got=%b want=1", busy); else passed++;
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if ({axi_awvalid, axi_arvalid, busy} !== 3'b0)
      $display("FAIL midreset_drop got=%b want=000", {axi_awvalid, axi_arvalid, busy}); else passed++;
    checks++; if (pass_cnt !== 16'h0) $display("FAIL midreset_pass_cnt got=%0d want=0", pass_cnt); else passed++;
    exp_pass = 0;
    @(negedge core_clk);
    i_rst_n = 1'b1;
    aw_hs = 0; ar_hs = 0;
    serve(1, 3000, 0, -1);
    exp_pass++;
    check_pass_result("restart", NB);
  endtask

  task automatic test_addr_pattern();
    cur_mode = 2; i_mode = 2'd2; aw_hs = 0; ar_hs = 0;
    pulse_start();
    serve(1, 3000, 0, -1);
    exp_pass++;
    check_pass_result("addr_pat", NB);
  endtask

  task automatic test_saturate();
    cur_mode = 3; i_mode = 2'd3; aw_hs = 0; ar_hs = 0;
    corrupt_all = 1; corrupt_bit = 0; long_rd = 1; long_len = 65520;
    pulse_start();
    serve(1, 80000, 0, -1);
    exp_pass++;
    check_pass_result("saturate", NB);
    checks++; if (err_cnt !== 16'hFFFF) $display("FAIL saturate_value got=%h want=ffff", err_cnt); else passed++;
    corrupt_all = 0; long_rd = 0;
  endtask

  initial begin
    test_reset();
    test_incr_basic();
    test_lfsr_error();
    test_loop();
    test_reset_mid();
    test_addr_pattern();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
